// File: rtl/mux_pipe_sel.sv
// NUM_IN:1 operand select stage with a 2-entry skid buffer and valid/ready handshake.
// Selection is resolved at the input, and out-of-range selects are flagged and counted.
module mux_pipe_sel #(
    parameter int WIDTH        = 16,
    parameter int NUM_IN       = 4,
    parameter int SEL_W        = 2,
    parameter bit SEL_OOR_ZERO = 1'b1,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              occupancy,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    input  logic                    err_clr
);

    localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];
    localparam bit             HAS_OOR  = (NUM_IN < (2 ** SEL_W));

    logic             main_valid, skid_valid, ready_q;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             main_err, skid_err;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept, issue;
    logic             skid_valid_nxt;

    always_comb begin
        sel_err  = HAS_OOR && ({1'b0, in_sel} >= NUM_IN_L);
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k))
                sel_data = in_data[k*WIDTH +: WIDTH];
        end
        if (sel_err)
            sel_data = SEL_OOR_ZERO ? '0 : in_data[WIDTH-1:0];
    end

    assign accept = in_valid & ready_q;
    assign issue  = main_valid & out_ready;

    // Skid is filled only when main stalls, and drained only when main issues.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (main_valid && issue)
            skid_valid_nxt = 1'b0;
        else if (main_valid && accept)
            skid_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q    <= !skid_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (!main_valid) begin
                if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= sel_data;
                    main_err   <= sel_err;
                end
            end else if (issue) begin
                if (skid_valid) begin
                    main_data <= skid_data;
                    main_err  <= skid_err;
                end else if (accept) begin
                    main_data <= sel_data;
                    main_err  <= sel_err;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= sel_data;
                skid_err  <= sel_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (accept && sel_err) ? ERR_CNT_W'(1) : '0;
        end else if (accept && sel_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = main_valid;
    assign out_data    = main_data;
    assign out_sel_err = main_err;
    assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed bench for mux_pipe_sel: a 4-input instance plus two 3-input instances
// (forced-zero and channel-0 out-of-range policy) driven in lockstep.
module tb_mux_pipe_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid, out_ready, err_clr;

    logic        a_in_ready, a_out_sel_err, a_out_valid;
    logic [15:0] a_out_data;
    logic [1:0]  a_occupancy;
    logic [7:0]  a_err_cnt;

    logic        b_in_ready, b_out_sel_err, b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_occupancy;
    logic [7:0]  b_err_cnt;

    logic        c_in_ready, c_out_sel_err, c_out_valid;
    logic [15:0] c_out_data;
    logic [1:0]  c_occupancy;
    logic [7:0]  c_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_pipe_sel #(.WIDTH(16), .NUM_IN(4), .SEL_W(2), .SEL_OOR_ZERO(1'b1), .ERR_CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_sel_err(a_out_sel_err),
        .out_valid(a_out_valid), .out_ready(out_ready), .occupancy(a_occupancy),
        .err_cnt(a_err_cnt), .err_clr(err_clr)
    );

    mux_pipe_sel #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .SEL_OOR_ZERO(1'b1), .ERR_CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[47:0]), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_sel_err(b_out_sel_err),
        .out_valid(b_out_valid), .out_ready(out_ready), .occupancy(b_occupancy),
        .err_cnt(b_err_cnt), .err_clr(err_clr)
    );

    mux_pipe_sel #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .SEL_OOR_ZERO(1'b0), .ERR_CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[47:0]), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_sel_err(c_out_sel_err),
        .out_valid(c_out_valid), .out_ready(out_ready), .occupancy(c_occupancy),
        .err_cnt(c_err_cnt), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] chan(input int beat, input int c);
        logic [3:0] b4, c4;
        b4 = 4'(beat);
        c4 = 4'(c);
        return {b4, c4, 8'hA5};
    endfunction

    task automatic load_beat(input int beat);
        for (int c = 0; c < 4; c++)
            in_data[c*16 +: 16] = chan(beat, c);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_sel_err", a_out_sel_err, 0);
        check("rst_occ", a_occupancy, 0);
        check("rst_err_cnt", a_err_cnt, 0);
        check("rst_in_ready", a_in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", a_in_ready, 1);

        // Single beat, sel=2
        in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_valid", a_out_valid, 1);
        check("t1_data", a_out_data, 16'h3333);
        check("t1_err", a_out_sel_err, 0);
        check("t1_occ", a_occupancy, 1);
        tick();
        check("t1_valid_gone", a_out_valid, 0);
        check("t1_occ_zero", a_occupancy, 0);

        // 16-beat stream at full throughput
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check("t2_valid", a_out_valid, 1);
                check("t2_data", a_out_data, chan(i - 1, (i - 1) % 4));
            end
            check("t2_ready", a_in_ready, 1);
            if (i < 16) begin
                load_beat(i);
                in_sel   = 2'(i % 4);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("t2_drained", a_out_valid, 0);

        // Backpressure: fill main and skid, then drain
        out_ready = 1'b0;
        in_sel    = 2'd1;
        load_beat(1);
        in_valid  = 1'b1;
        tick();
        check("t3_ready1", a_in_ready, 1);
        check("t3_occ1", a_occupancy, 1);
        check("t3_data_a", a_out_data, chan(1, 1));
        load_beat(2);
        tick();
        check("t3_ready_low", a_in_ready, 0);
        check("t3_occ2", a_occupancy, 2);
        check("t3_hold_a", a_out_data, chan(1, 1));
        load_beat(3);
        tick();
        check("t3_still_full", a_occupancy, 2);
        check("t3_still_low", a_in_ready, 0);
        check("t3_stable_a", a_out_data, chan(1, 1));
        out_ready = 1'b1;
        tick();
        check("t3_data_b", a_out_data, chan(2, 1));
        check("t3_occ_b", a_occupancy, 1);
        check("t3_ready_back", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t3_data_c", a_out_data, chan(3, 1));
        check("t3_occ_c", a_occupancy, 1);
        tick();
        check("t3_empty", a_occupancy, 0);
        check("t3_valid_low", a_out_valid, 0);

        // Out-of-range select on 3-input instances
        do_reset();
        in_data   = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t4_b_valid", b_out_valid, 1);
        check("t4_b_data", b_out_data, 0);
        check("t4_b_err", b_out_sel_err, 1);
        check("t4_b_cnt", b_err_cnt, 1);
        check("t4_c_data", c_out_data, 16'hBEEF);
        check("t4_c_err", c_out_sel_err, 1);
        check("t4_a_data", a_out_data, 16'h4444);
        check("t4_a_err", a_out_sel_err, 0);
        check("t4_a_cnt", a_err_cnt, 0);
        tick();

        // Counter saturation and clear priority
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++)
            tick();
        check("t5_sat_b", b_err_cnt, 8'hFF);
        check("t5_sat_c", c_err_cnt, 8'hFF);
        check("t5_a_cnt", a_err_cnt, 0);
        err_clr = 1'b1;
        tick();
        check("t5_clr_err", b_err_cnt, 1);
        in_valid = 1'b0;
        tick();
        check("t5_clr_only", b_err_cnt, 0);
        err_clr = 1'b0;
        tick();

        // Asynchronous reset with both entries held
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("t6_occ2", a_occupancy, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", a_out_valid, 0);
        check("t6_async_occ", a_occupancy, 0);
        check("t6_async_ready", a_in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_ready_release", a_in_ready, 1);
        check("t6_valid_release", a_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
